// File: rtl/line_buffer_ctrl.sv
// Write-side controller for a 3-line buffer feeding a 3x3 window consumer.
// Tracks pixel position, gates shifting on downstream backpressure, and flags line/frame ends.
module line_buffer_ctrl #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = 10,
    parameter int ROW_W      = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             pixel_valid,
    input  logic             ds_ready,
    output logic             shift_en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             window_valid,
    output logic             line_done,
    output logic             frame_done,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, FILL, STREAM, STALL} state_t;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

    state_t           r_state;
    state_t           r_resume;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_window_valid;
    logic             r_line_done;
    logic             r_frame_done;
    logic             r_overflow;

    logic w_active;
    logic w_accept;
    logic w_eol;
    logic w_eof;
    logic w_win;

    assign w_active = (r_state == FILL) || (r_state == STREAM);
    assign w_accept = pixel_valid && ds_ready && w_active;
    assign w_eol    = (r_col == LAST_COL);
    assign w_eof    = w_eol && (r_row == LAST_ROW);
    // A full 3x3 neighbourhood exists once two prior rows and two prior columns are buffered.
    assign w_win    = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_resume       <= FILL;
            r_col          <= '0;
            r_row          <= '0;
            r_window_valid <= 1'b0;
            r_line_done    <= 1'b0;
            r_frame_done   <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_window_valid <= 1'b0;
            r_line_done    <= 1'b0;
            r_frame_done   <= 1'b0;
            // frame_start wins over everything, including a coincident accept.
            if (frame_start) begin
                r_state    <= FILL;
                r_col      <= '0;
                r_row      <= '0;
                r_overflow <= 1'b0;
            end else begin
                if (pixel_valid && !ds_ready && (r_state != IDLE))
                    r_overflow <= 1'b1;
                case (r_state)
                    IDLE: begin
                        r_state <= IDLE;
                    end
                    FILL, STREAM: begin
                        if (!ds_ready) begin
                            r_resume <= r_state;
                            r_state  <= STALL;
                        end else if (w_accept) begin
                            r_window_valid <= w_win;
                            r_line_done    <= w_eol;
                            if (w_eol) begin
                                r_col <= '0;
                                if (w_eof) begin
                                    r_row        <= '0;
                                    r_frame_done <= 1'b1;
                                    r_state      <= IDLE;
                                end else begin
                                    r_row <= r_row + ROW_W'(1);
                                    if ((r_state == FILL) && (r_row == ROW_W'(1)))
                                        r_state <= STREAM;
                                end
                            end else begin
                                r_col <= r_col + COL_W'(1);
                            end
                        end
                    end
                    STALL: begin
                        if (ds_ready)
                            r_state <= r_resume;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign shift_en     = w_accept;
    assign col          = r_col;
    assign row          = r_row;
    assign window_valid = r_window_valid;
    assign line_done    = r_line_done;
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl on a reduced 8x6 frame.
module tb_line_buffer_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 4;
    localparam int RW = 3;

    logic          clk;
    logic          rst;
    logic          frame_start;
    logic          pixel_valid;
    logic          ds_ready;
    logic          shift_en;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          window_valid;
    logic          line_done;
    logic          frame_done;
    logic          overflow;
    logic          busy;

    int n_checks = 0;
    int n_errors = 0;
    int sh_cnt = 0;
    int ld_cnt = 0;
    int fd_cnt = 0;
    int wv_cnt = 0;
    int s_sh, s_ld, s_fd, s_wv;

    line_buffer_ctrl #(
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H),
        .COL_W     (CW),
        .ROW_W     (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .pixel_valid (pixel_valid),
        .ds_ready    (ds_ready),
        .shift_en    (shift_en),
        .col         (col),
        .row         (row),
        .window_valid(window_valid),
        .line_done   (line_done),
        .frame_done  (frame_done),
        .overflow    (overflow),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event tallies; registered pulses are seen one edge after they are set.
    always @(posedge clk) begin
        if (shift_en === 1'b1)     sh_cnt++;
        if (line_done === 1'b1)    ld_cnt++;
        if (frame_done === 1'b1)   fd_cnt++;
        if (window_valid === 1'b1) wv_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic pv, input logic rdy, input logic fs);
        pixel_valid = pv;
        ds_ready    = rdy;
        frame_start = fs;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drv(1'b1, 1'b1, 1'b0);
            tick();
        end
    endtask

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_shift_en"}, 32'(shift_en), 0);
        chk({pfx, "_col"}, 32'(col), 0);
        chk({pfx, "_row"}, 32'(row), 0);
        chk({pfx, "_wv"}, 32'(window_valid), 0);
        chk({pfx, "_line_done"}, 32'(line_done), 0);
        chk({pfx, "_frame_done"}, 32'(frame_done), 0);
        chk({pfx, "_overflow"}, 32'(overflow), 0);
        chk({pfx, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        rst = 1'b0;
        frame_start = 1'b0;
        pixel_valid = 1'b1;
        ds_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // IDLE ignores pixels, with or without backpressure
        drv(1'b1, 1'b1, 1'b0);
        chk("idle_shift", 32'(shift_en), 0);
        tick();
        drv(1'b1, 1'b0, 1'b0);
        tick();
        chk("idle_ovf", 32'(overflow), 0);
        chk("idle_busy", 32'(busy), 0);

        // Frame 1: fill two lines
        drv(1'b0, 1'b1, 1'b1);
        tick();
        drv(1'b0, 1'b1, 1'b0);
        chk("f1_busy", 32'(busy), 1);
        chk("f1_col0", 32'(col), 0);
        s_sh = sh_cnt; s_ld = ld_cnt; s_fd = fd_cnt; s_wv = wv_cnt;
        run(2 * W);
        chk("fill_shifts", 32'(sh_cnt - s_sh), 2 * W);
        chk("fill_wv_cnt", 32'(wv_cnt - s_wv), 0);
        chk("fill_wv", 32'(window_valid), 0);
        chk("fill_row", 32'(row), 2);
        chk("fill_col", 32'(col), 0);
        chk("fill_ld", 32'(line_done), 1);

        // Row 2: window becomes valid after the col 2 accept
        drv(1'b1, 1'b1, 1'b0);
        chk("r2_shift", 32'(shift_en), 1);
        tick();
        chk("r2c0_wv", 32'(window_valid), 0);
        chk("r2c0_ld", 32'(line_done), 0);
        run(1);
        chk("r2c1_wv", 32'(window_valid), 0);
        run(1);
        chk("r2c2_wv", 32'(window_valid), 1);
        chk("r2c2_col", 32'(col), 3);
        run(4);
        chk("r2c6_ld", 32'(line_done), 0);
        run(1);
        chk("r2c7_ld", 32'(line_done), 1);
        chk("r2c7_wv", 32'(window_valid), 1);
        chk("r3_row", 32'(row), 3);

        // Row 3: stall five cycles mid-row with pixels still arriving
        run(4);
        drv(1'b1, 1'b0, 1'b0);
        chk("stall_shift0", 32'(shift_en), 0);
        tick();
        chk("stall_ovf", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 1'b0, 1'b0);
            chk("stall_shift", 32'(shift_en), 0);
            tick();
            chk("stall_col", 32'(col), 4);
            chk("stall_row", 32'(row), 3);
        end
        drv(1'b1, 1'b1, 1'b0);
        chk("stall_exit_shift", 32'(shift_en), 0);
        tick();
        chk("resume_col", 32'(col), 4);
        drv(1'b1, 1'b1, 1'b0);
        chk("resume_shift", 32'(shift_en), 1);
        run(20);
        chk("f1_frame_done", 32'(frame_done), 1);
        chk("f1_busy_end", 32'(busy), 0);
        chk("f1_ovf_sticky", 32'(overflow), 1);
        chk("f1_row_end", 32'(row), 0);
        drv(1'b1, 1'b1, 1'b0);
        chk("f1_idle_shift", 32'(shift_en), 0);
        tick();
        chk("f1_fd_pulse", 32'(frame_done), 0);
        tick();
        chk("f1_total_shift", 32'(sh_cnt - s_sh), W * H);
        chk("f1_total_ld", 32'(ld_cnt - s_ld), H);
        chk("f1_total_fd", 32'(fd_cnt - s_fd), 1);

        // Frame 2: aborted at row 2 col 5 by a frame_start coincident with an accept
        drv(1'b0, 1'b1, 1'b1);
        tick();
        chk("f2_ovf_clr", 32'(overflow), 0);
        chk("f2_busy", 32'(busy), 1);
        s_fd = fd_cnt;
        run(2 * W + 5);
        chk("f2_col", 32'(col), 5);
        chk("f2_row", 32'(row), 2);
        drv(1'b1, 1'b1, 1'b1);
        tick();
        chk("abort_col", 32'(col), 0);
        chk("abort_row", 32'(row), 0);
        chk("abort_wv", 32'(window_valid), 0);
        chk("abort_busy", 32'(busy), 1);
        drv(1'b1, 1'b1, 1'b0);
        chk("abort_next_shift", 32'(shift_en), 1);
        tick();
        chk("abort_next_col", 32'(col), 1);
        tick();
        chk("abort_no_fd", 32'(fd_cnt - s_fd), 0);
        run(W * H - 2);
        chk("f3_frame_done", 32'(frame_done), 1);
        drv(1'b0, 1'b1, 1'b0);
        tick();
        tick();
        chk("f3_fd_count", 32'(fd_cnt - s_fd), 1);

        // Reset mid-frame with nonzero state
        drv(1'b0, 1'b1, 1'b1);
        tick();
        run(2 * W + 4);
        drv(1'b1, 1'b0, 1'b0);
        tick();
        run(2);
        chk("pre_rst_ovf", 32'(overflow), 1);
        chk("pre_rst_wv", 32'(window_valid), 1);
        drv(1'b1, 1'b1, 1'b0);
        chk("pre_rst_shift", 32'(shift_en), 1);
        #1;
        rst = 1'b0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 1'b1, 1'b0);
            chk("post_rst_shift", 32'(shift_en), 0);
            tick();
            chk("post_rst_col", 32'(col), 0);
        end
        drv(1'b0, 1'b1, 1'b1);
        tick();
        drv(1'b1, 1'b1, 1'b0);
        chk("restart_shift", 32'(shift_en), 1);
        tick();
        chk("restart_col", 32'(col), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
